spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 141 ++++++++++++++
 tb/tb_spi_slave.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI mode-0 slave: synchronizes ss_n/sck/mosi into clk, shifts bytes MSB first.
// Optional SPI_SLAVE_UNDERRUN_EN adds a tx_underrun pulse on every 8'hFF fill.
module spi_slave (
    input  logic       clk,
    input  logic       rst,
    input  logic       ss_n,
    input  logic       sck,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
`ifdef SPI_SLAVE_UNDERRUN_EN
    output logic       tx_underrun,
`endif
    output logic       busy
);
    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t     r_state, w_state_nxt;
    logic       r_ss_s1, r_ss_s2, r_ss_h;
    logic       r_sck_s1, r_sck_s2, r_sck_h;
    logic       r_mosi_s1, r_mosi_s2;
    logic [1:0] r_arm_dly;
    logic       r_armed;
    logic [7:0] r_tx_sr, w_tx_nxt;
    logic [7:0] r_rx_sr, w_rx_byte;
    logic [2:0] r_cnt;
    logic       r_done;
    logic       r_miso, r_tx_ack, r_rx_valid, r_underrun;
    logic [7:0] r_rx_data;
    logic       w_load;
    logic       w_ss_fall, w_ss_rise, w_sck_rise, w_sck_fall;

    assign w_ss_fall  =  r_ss_h  & ~r_ss_s2;
    assign w_ss_rise  = ~r_ss_h  &  r_ss_s2;
    assign w_sck_rise = ~r_sck_h &  r_sck_s2;
    assign w_sck_fall =  r_sck_h & ~r_sck_s2;
    assign w_rx_byte  = {r_rx_sr[6:0], r_mosi_s2};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ss_s1   <= 1'b1; r_ss_s2   <= 1'b1; r_ss_h  <= 1'b1;
            r_sck_s1  <= 1'b0; r_sck_s2  <= 1'b0; r_sck_h <= 1'b0;
            r_mosi_s1 <= 1'b0; r_mosi_s2 <= 1'b0;
            r_arm_dly <= 2'b00;
            r_armed   <= 1'b0;
        end else begin
            r_ss_s1   <= ss_n;  r_ss_s2   <= r_ss_s1;  r_ss_h  <= r_ss_s2;
            r_sck_s1  <= sck;   r_sck_s2  <= r_sck_s1; r_sck_h <= r_sck_s2;
            r_mosi_s1 <= mosi;  r_mosi_s2 <= r_mosi_s1;
            r_arm_dly <= {r_arm_dly[0], 1'b1};
            // Once the synchronizer holds real samples, require ss_n seen high so a
            // select still low across reset never looks like a fresh falling edge.
            r_armed   <= r_armed | (r_arm_dly[1] & r_ss_s2);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ss_fall && r_armed) begin
                    w_state_nxt = ACTIVE;
                    w_load      = 1'b1;
                end
            end
            ACTIVE: begin
                if (w_ss_rise)                w_state_nxt = IDLE;
                else if (w_sck_fall && r_done) w_load      = 1'b1;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_tx_nxt = r_tx_sr;
        if (w_load)
            w_tx_nxt = tx_valid ? tx_data : 8'hFF;
        else if (r_state == ACTIVE && !w_ss_rise && w_sck_fall && !r_done)
            w_tx_nxt = {r_tx_sr[6:0], 1'b0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_sr    <= 8'h00;
            r_rx_sr    <= 8'h00;
            r_cnt      <= 3'd0;
            r_done     <= 1'b0;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_tx_ack   <= 1'b0;
            r_underrun <= 1'b0;
            r_miso     <= 1'b0;
        end else begin
            r_tx_sr    <= w_tx_nxt;
            r_tx_ack   <= w_load &  tx_valid;
            r_underrun <= w_load & ~tx_valid;
            r_rx_valid <= 1'b0;
            r_miso     <= (w_state_nxt == ACTIVE) ? w_tx_nxt[7] : 1'b0;
            if (r_state == IDLE) begin
                if (w_load) begin
                    r_cnt   <= 3'd0;
                    r_done  <= 1'b0;
                    r_rx_sr <= 8'h00;
                end
            end else if (w_ss_rise) begin
                r_cnt   <= 3'd0;
                r_done  <= 1'b0;
                r_rx_sr <= 8'h00;
            end else if (w_sck_rise) begin
                r_rx_sr <= w_rx_byte;
                r_cnt   <= r_cnt + 3'd1;
                if (r_cnt == 3'd7) begin
                    r_rx_data  <= w_rx_byte;
                    r_rx_valid <= 1'b1;
                    r_done     <= 1'b1;
                end
            end else if (w_sck_fall && r_done) begin
                r_done <= 1'b0;
            end
        end
    end

    assign miso     = r_miso;
    assign tx_ack   = r_tx_ack;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign busy     = (r_state == ACTIVE);
`ifdef SPI_SLAVE_UNDERRUN_EN
    assign tx_underrun = r_underrun;
`endif
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: mode-0 master model, pulse counters, immediate assertions.
module tb_spi_slave;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ss_n = 1'b1, sck = 1'b0, mosi = 1'b0, tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       miso, tx_ack, rx_valid, busy;
    logic [7:0] rx_data;
`ifdef SPI_SLAVE_UNDERRUN_EN
    logic       tx_underrun;
`endif

    spi_slave dut (
        .clk(clk), .rst(rst), .ss_n(ss_n), .sck(sck), .mosi(mosi), .miso(miso),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ack(tx_ack),
        .rx_data(rx_data), .rx_valid(rx_valid),
`ifdef SPI_SLAVE_UNDERRUN_EN
        .tx_underrun(tx_underrun),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int n_rx = 0, n_ack = 0, n_und = 0;
    logic [7:0] rx_log [0:15];

    always @(posedge clk) begin
        if (rx_valid) begin
            rx_log[n_rx % 16] <= rx_data;
            n_rx <= n_rx + 1;
        end
        if (tx_ack) n_ack <= n_ack + 1;
`ifdef SPI_SLAVE_UNDERRUN_EN
        if (tx_underrun) n_und <= n_und + 1;
`endif
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode-0 master: mosi changes with sck low, miso sampled at sck rise.
    // nv/nd are presented after the first rise, ahead of the next reload.
    task automatic spi_bits(input logic [7:0] mo, input int nbits, input logic nv,
                            input logic [7:0] nd, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = mo[i];
            tick(8);
            sck   = 1'b1;
            mi[i] = miso;
            if (i == 7) begin
                tx_valid = nv;
                tx_data  = nd;
            end
            tick(8);
            sck = 1'b0;
        end
        tick(8);
    endtask

    logic [7:0] m1, m2;
    int a0, r0, u0;

    initial begin
        tick(4);
        check("rst_busy", busy, 1'b0);
        check("rst_miso", miso, 1'b0);
        check("rst_tx_ack", tx_ack, 1'b0);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        rst = 1'b0;
        tick(6);

        // single byte
        tx_data = 8'hA5; tx_valid = 1'b1;
        a0 = n_ack; r0 = n_rx; u0 = n_und;
        ss_n = 1'b0; tick(8);
        check("single_busy", busy, 1'b1);
        spi_bits(8'h3C, 8, 1'b0, 8'h00, m1);
        ss_n = 1'b1; tick(10);
        check("single_miso", m1, 8'hA5);
        check("single_rx_data", rx_data, 8'h3C);
        check("single_rx_cnt", n_rx - r0, 1);
        check("single_ack_cnt", n_ack - a0, 1);
        check("single_idle_busy", busy, 1'b0);
`ifdef SPI_SLAVE_UNDERRUN_EN
        check("single_und_cnt", n_und - u0, 1);
`endif

        // two bytes under one select
        tx_data = 8'h81; tx_valid = 1'b1;
        a0 = n_ack; r0 = n_rx;
        ss_n = 1'b0; tick(8);
        spi_bits(8'h11, 8, 1'b1, 8'h7E, m1);
        spi_bits(8'h22, 8, 1'b0, 8'h00, m2);
        ss_n = 1'b1; tick(10);
        check("b2b_miso0", m1, 8'h81);
        check("b2b_miso1", m2, 8'h7E);
        check("b2b_rx_cnt", n_rx - r0, 2);
        check("b2b_rx0", rx_log[r0 % 16], 8'h11);
        check("b2b_rx1", rx_log[(r0 + 1) % 16], 8'h22);
        check("b2b_ack_cnt", n_ack - a0, 2);

        // underrun: load and end-of-byte reload both fill 8'hFF
        tx_valid = 1'b0;
        a0 = n_ack; u0 = n_und;
        ss_n = 1'b0; tick(8);
        spi_bits(8'h96, 8, 1'b0, 8'h00, m1);
        ss_n = 1'b1; tick(10);
        check("und_miso", m1, 8'hFF);
        check("und_ack_cnt", n_ack - a0, 0);
        check("und_rx_data", rx_data, 8'h96);
`ifdef SPI_SLAVE_UNDERRUN_EN
        check("und_pulse_cnt", n_und - u0, 2);
`endif

        // deselect after 5 bits, then a full byte
        r0 = n_rx;
        ss_n = 1'b0; tick(8);
        spi_bits(8'hF0, 5, 1'b0, 8'h00, m1);
        ss_n = 1'b1; tick(10);
        check("desel_rx_cnt", n_rx - r0, 0);
        check("desel_rx_data", rx_data, 8'h96);
        check("desel_busy", busy, 1'b0);
        ss_n = 1'b0; tick(8);
        spi_bits(8'h5A, 8, 1'b0, 8'h00, m1);
        ss_n = 1'b1; tick(10);
        check("desel_next_rx", rx_data, 8'h5A);
        check("desel_next_cnt", n_rx - r0, 1);

        // reset mid-transfer with ss_n held low
        tx_data = 8'hA5; tx_valid = 1'b1;
        r0 = n_rx;
        ss_n = 1'b0; tick(8);
        spi_bits(8'hE0, 3, 1'b1, 8'hA5, m1);
        rst = 1'b1; tick(2);
        check("mrst_busy", busy, 1'b0);
        check("mrst_miso", miso, 1'b0);
        check("mrst_rx_data", rx_data, 8'h00);
        check("mrst_tx_ack", tx_ack, 1'b0);
        check("mrst_rx_valid", rx_valid, 1'b0);
        rst = 1'b0; tick(10);
        check("mrst_still_idle", busy, 1'b0);
        a0 = n_ack;
        spi_bits(8'hAA, 8, 1'b1, 8'hA5, m1);
        check("mrst_no_rx", n_rx - r0, 0);
        check("mrst_no_ack", n_ack - a0, 0);
        check("mrst_no_miso", m1, 8'h00);
        check("mrst_busy_after", busy, 1'b0);
        ss_n = 1'b1; tick(10);
        ss_n = 1'b0; tick(8);
        spi_bits(8'hC3, 8, 1'b0, 8'h00, m1);
        ss_n = 1'b1; tick(10);
        check("mrst_new_rx", rx_data, 8'hC3);
        check("mrst_new_miso", m1, 8'hA5);

        // idle noise: 16 sck toggles with ss_n high
        tx_valid = 1'b1;
        r0 = n_rx; a0 = n_ack;
        for (int i = 0; i < 16; i++) begin
            mosi = i[1];
            sck  = ~sck;
            tick(4);
            if (miso !== 1'b0) check("noise_miso_step", miso, 1'b0);
        end
        tick(8);
        check("noise_rx_cnt", n_rx - r0, 0);
        check("noise_ack_cnt", n_ack - a0, 0);
        check("noise_miso", miso, 1'b0);
        check("noise_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
